// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg : default 640x480@60 timing, pixel layout and sizing helpers      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vga_pkg;

    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_COLOR_W    = 4;
    localparam int DEF_RD_LATENCY = 2;

    // Same {r,g,b} ordering, red in the MSBs, as the frame-store words.
    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } pixel_t;

    function automatic int line_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_gen : h/v counters and registered counter-stage flags         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         active,
    output logic [$clog2(H_VISIBLE)-1:0] x,
    output logic [$clog2(V_VISIBLE)-1:0] y,
    output logic                         hs,
    output logic                         vs,
    output logic                         frame_start,
    output logic                         swap_pt
);

    localparam int H_TOTAL  = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL  = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int HW       = cnt_width(H_TOTAL);
    localparam int VW       = cnt_width(V_TOTAL);
    localparam int XW       = $clog2(H_VISIBLE);
    localparam int YW       = $clog2(V_VISIBLE);
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

    // Counters hold the position presented next; every stage flag is a flop
    // loaded from them, so the first cycle after reset release shows (0,0).
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          vis;

    assign vis = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            frame_start <= 1'b0;
            swap_pt     <= 1'b0;
        end else begin
            active      <= vis;
            x           <= vis ? h_cnt[XW-1:0] : '0;
            y           <= vis ? v_cnt[YW-1:0] : '0;
            hs          <= (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
            vs          <= (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            swap_pt     <= (h_cnt == '0) && (int'(v_cnt) == V_VISIBLE);
            if (int'(h_cnt) == H_TOTAL - 1) begin
                h_cnt <= '0;
                v_cnt <= (int'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_scanout : VGA timing, frame-store fetch, double-buffer swap at vblank |
// | Option macro VGA_SCANOUT_TEST_PATTERN_EN adds test_en colour bars.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic                         test_en,
`endif
    output logic                         rd_en,
    output logic [$clog2(H_VISIBLE)-1:0] rd_x,
    output logic [$clog2(V_VISIBLE)-1:0] rd_y,
    output logic                         rd_buf,
    input  logic [3*COLOR_W-1:0]         rd_data,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         front_sel,
    output logic                         frame_start,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         de,
    output logic [COLOR_W-1:0]           red,
    output logic [COLOR_W-1:0]           green,
    output logic [COLOR_W-1:0]           blue
);

    localparam int XW = $clog2(H_VISIBLE);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int DW    = 3 + XW;
    localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
`else
    localparam int DW    = 3;
`endif

    logic          st_hs;
    logic          st_vs;
    logic          swap_pt;
    logic [DW-1:0] stage_flags;
    logic [DW-1:0] dly [RD_LATENCY];
    logic [DW-1:0] tail;
    logic          d_act;
    logic          d_hs;
    logic          d_vs;
    logic [3*COLOR_W-1:0] pix;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (rd_en),
        .x           (rd_x),
        .y           (rd_y),
        .hs          (st_hs),
        .vs          (st_vs),
        .frame_start (frame_start),
        .swap_pt     (swap_pt)
    );

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    assign stage_flags = {rd_en, st_hs, st_vs, rd_x};
`else
    assign stage_flags = {rd_en, st_hs, st_vs};
`endif

    // Flags travel alongside the frame-store read so sync, de and colour
    // all land on the pins in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= stage_flags;
            for (int i = 1; i < RD_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

    assign tail  = dly[RD_LATENCY-1];
    assign d_act = tail[DW-1];
    assign d_hs  = tail[DW-2];
    assign d_vs  = tail[DW-3];

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [XW-1:0] d_x;
    logic [2:0]    bar;
    int            bar_idx;

    assign d_x = tail[XW-1:0];

    always_comb begin
        bar_idx = int'(d_x) / BAR_W;
        if (bar_idx > 7) bar_idx = 7;
        bar = 3'(bar_idx);
        pix = test_en ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}} : rd_data;
    end
`else
    assign pix = rd_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= ~HSYNC_POL;
            vsync <= ~VSYNC_POL;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            hsync <= d_hs ? HSYNC_POL : ~HSYNC_POL;
            vsync <= d_vs ? VSYNC_POL : ~VSYNC_POL;
            de    <= d_act;
            {red, green, blue} <= d_act ? pix : '0;
        end
    end

    // The swap point sits in vertical blank, so the buffer never changes
    // while visible lines are being fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
        end else begin
            swap_ack <= swap_pt && swap_req;
            if (swap_pt && swap_req) front_sel <= ~front_sel;
        end
    end

    assign rd_buf = front_sel;

endmodule
`default_nettype wire
